// File: rtl/nco_clk_gen_if.sv
// nco_clk_gen_if: control and status bundle for the multi-channel NCO clock
// generator. Carries the per-channel enable, the FCW valid/ready handshake,
// the shared slew step and the generated clock/tick/lock outputs.
// The slave modport is the generator side; the master modport is the
// controller side.
interface nco_clk_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SLEW_W = 16
);

  logic [NUM_CH-1:0]            en_i;
  logic [NUM_CH-1:0][ACC_W-1:0] fcw_i;
  logic [NUM_CH-1:0]            fcw_valid_i;
  logic [NUM_CH-1:0]            fcw_ready_o;
  logic [SLEW_W-1:0]            slew_step_i;
  logic [NUM_CH-1:0]            clk_o;
  logic [NUM_CH-1:0]            tick_o;
  logic [NUM_CH-1:0]            locked_o;

  modport slave (
    input  en_i,
    input  fcw_i,
    input  fcw_valid_i,
    output fcw_ready_o,
    input  slew_step_i,
    output clk_o,
    output tick_o,
    output locked_o
  );

  modport master (
    output en_i,
    output fcw_i,
    output fcw_valid_i,
    input  fcw_ready_o,
    output slew_step_i,
    input  clk_o,
    input  tick_o,
    input  locked_o
  );

endinterface

// File: rtl/nco_clk_gen.sv
// nco_clk_gen: multi-channel numerically controlled clock generator.
// Each channel owns a phase accumulator advanced by its current FCW. New
// FCWs arrive over a valid/ready handshake and the current FCW is
// slew-limited toward the target, so frequency ramps instead of stepping.
// Output frequency per channel is f_clk * FCW / 2^ACC_W.
//
// Optional build macro NCO_SYNC_EN: adds sync_i, a pulse that clears the
// accumulator of every channel in RAMP or RUN on the next edge.
module nco_clk_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SLEW_W = 16
) (
  input  logic clk_i,
  input  logic arst_ni,
`ifdef NCO_SYNC_EN
  input  logic sync_i,
`endif
  nco_clk_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e            state_q   [NUM_CH];
  state_e            state_d   [NUM_CH];
  logic [ACC_W-1:0]  acc_q     [NUM_CH];
  logic [ACC_W-1:0]  acc_d     [NUM_CH];
  logic [ACC_W-1:0]  cur_fcw_q [NUM_CH];
  logic [ACC_W-1:0]  cur_fcw_d [NUM_CH];
  logic [ACC_W-1:0]  tgt_fcw_q [NUM_CH];
  logic [ACC_W-1:0]  tgt_fcw_d [NUM_CH];
  logic [ACC_W:0]    sum_s     [NUM_CH];
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] accept_s;
  logic              sync_s;

`ifdef NCO_SYNC_EN
  assign sync_s = sync_i;
`else
  assign sync_s = 1'b0;
`endif

  // Move cur one slew step toward tgt; a zero step or a remaining distance
  // no larger than the step lands exactly on tgt, so it never overshoots.
  function automatic logic [ACC_W-1:0] ramp_next(
    input logic [ACC_W-1:0]  cur,
    input logic [ACC_W-1:0]  tgt,
    input logic [SLEW_W-1:0] step
  );
    logic [ACC_W-1:0] step_ext;
    logic [ACC_W-1:0] delta;
    logic [ACC_W-1:0] res;
    step_ext = ACC_W'(step);
    if (tgt >= cur) begin
      delta = tgt - cur;
    end else begin
      delta = cur - tgt;
    end
    if ((step_ext == {ACC_W{1'b0}}) || (step_ext >= delta)) begin
      res = tgt;
    end else if (tgt > cur) begin
      res = cur + step_ext;
    end else begin
      res = cur - step_ext;
    end
    return res;
  endfunction

  // Per-channel next-state, handshake, ramp and accumulator logic.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      accept_s[ch]  = bus.fcw_valid_i[ch] && (state_q[ch] != ST_RAMP);
      sum_s[ch]     = {1'b0, acc_q[ch]} + {1'b0, cur_fcw_q[ch]};
      state_d[ch]   = state_q[ch];
      acc_d[ch]     = acc_q[ch];
      cur_fcw_d[ch] = cur_fcw_q[ch];
      tgt_fcw_d[ch] = accept_s[ch] ? bus.fcw_i[ch] : tgt_fcw_q[ch];
      clk_d[ch]     = 1'b0;
      tick_d[ch]    = 1'b0;

      if (!bus.en_i[ch]) begin
        // Disabled: park in IDLE with a cleared phase, keep both FCWs.
        state_d[ch] = ST_IDLE;
        acc_d[ch]   = {ACC_W{1'b0}};
      end else begin
        clk_d[ch] = acc_q[ch][ACC_W-1];
        case (state_q[ch])
          ST_IDLE: begin
            // Compare against the post-transfer target so a word accepted
            // on the enabling edge is not lost.
            if (cur_fcw_q[ch] == tgt_fcw_d[ch]) begin
              state_d[ch] = ST_RUN;
            end else begin
              state_d[ch] = ST_RAMP;
            end
          end
          ST_RAMP: begin
            acc_d[ch]     = sync_s ? {ACC_W{1'b0}} : sum_s[ch][ACC_W-1:0];
            tick_d[ch]    = sync_s ? 1'b0 : sum_s[ch][ACC_W];
            cur_fcw_d[ch] = ramp_next(cur_fcw_q[ch], tgt_fcw_q[ch],
                                      bus.slew_step_i);
            if (cur_fcw_d[ch] == tgt_fcw_q[ch]) begin
              state_d[ch] = ST_RUN;
            end else begin
              state_d[ch] = ST_RAMP;
            end
          end
          ST_RUN: begin
            acc_d[ch]  = sync_s ? {ACC_W{1'b0}} : sum_s[ch][ACC_W-1:0];
            tick_d[ch] = sync_s ? 1'b0 : sum_s[ch][ACC_W];
            if (accept_s[ch] && (bus.fcw_i[ch] != cur_fcw_q[ch])) begin
              state_d[ch] = ST_RAMP;
            end else begin
              state_d[ch] = ST_RUN;
            end
          end
          default: begin
            state_d[ch] = ST_IDLE;
            acc_d[ch]   = {ACC_W{1'b0}};
          end
        endcase
      end
    end
  end

  // State, accumulator, FCW and output registers for all channels.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch]   <= ST_IDLE;
        acc_q[ch]     <= {ACC_W{1'b0}};
        cur_fcw_q[ch] <= {ACC_W{1'b0}};
        tgt_fcw_q[ch] <= {ACC_W{1'b0}};
      end
      clk_q  <= {NUM_CH{1'b0}};
      tick_q <= {NUM_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch]   <= state_d[ch];
        acc_q[ch]     <= acc_d[ch];
        cur_fcw_q[ch] <= cur_fcw_d[ch];
        tgt_fcw_q[ch] <= tgt_fcw_d[ch];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  // Status outputs decoded straight from the registered state.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus.fcw_ready_o[ch] = (state_q[ch] != ST_RAMP);
      bus.locked_o[ch]    = (state_q[ch] == ST_RUN);
    end
    bus.clk_o  = clk_q;
    bus.tick_o = tick_q;
  end

endmodule

// File: tb/tb_nco_clk_gen.sv
// tb_nco_clk_gen: directed self-checking bench for nco_clk_gen.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_nco_clk_gen;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned SLEW_W = 16;

  logic clk;
  logic rst_n;
`ifdef NCO_SYNC_EN
  logic sync;
`endif

  int total;
  int bad;

  nco_clk_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SLEW_W(SLEW_W)) bus ();

  nco_clk_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SLEW_W(SLEW_W)) dut (
    .clk_i   (clk),
    .arst_ni (rst_n),
`ifdef NCO_SYNC_EN
    .sync_i  (sync),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last;
    int cnt;
    int first0;
    int first1;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
`ifdef NCO_SYNC_EN
    sync = 1'b0;
`endif
    bus.en_i        = 4'b0000;
    bus.fcw_i       = '0;
    bus.fcw_valid_i = 4'b0000;
    bus.slew_step_i = 16'h0000;

    // ---------------- reset state ----------------
    #1;
    check("rst_clk",    64'(bus.clk_o),       64'h0);
    check("rst_tick",   64'(bus.tick_o),      64'h0);
    check("rst_locked", 64'(bus.locked_o),    64'h0);
    check("rst_ready",  64'(bus.fcw_ready_o), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- basic rate on ch0 ----------------
    bus.fcw_i[0] = 32'h4000_0000;
    bus.fcw_valid_i[0] = 1'b1;
    step();
    bus.fcw_valid_i[0] = 1'b0;
    check("idle_tgt",    64'(dut.tgt_fcw_q[0]), 64'h4000_0000);
    check("idle_cur",    64'(dut.cur_fcw_q[0]), 64'h0);
    check("idle_locked", 64'(bus.locked_o[0]),  64'h0);
    check("idle_ready",  64'(bus.fcw_ready_o[0]), 64'h1);
    bus.en_i[0] = 1'b1;
    step();
    check("ramp_ready0", 64'(bus.fcw_ready_o[0]), 64'h0);
    step();
    check("run_locked0", 64'(bus.locked_o[0]),  64'h1);
    check("run_cur0",    64'(dut.cur_fcw_q[0]), 64'h4000_0000);
    check("run_acc0",    64'(dut.acc_q[0]),     64'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rate_tick0", 64'(bus.tick_o[0]), ((k % 4) == 3) ? 64'h1 : 64'h0);
      check("rate_clk0",  64'(bus.clk_o[0]),  ((k % 4) >= 2) ? 64'h1 : 64'h0);
    end

    // ---------------- slew ramp on ch2 ----------------
    bus.slew_step_i = 16'h0000;
    bus.fcw_i[2] = 32'h0000_1000;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    bus.en_i[2] = 1'b1;
    step();
    step();
    check("slew_pre_locked", 64'(bus.locked_o[2]),  64'h1);
    check("slew_pre_cur",    64'(dut.cur_fcw_q[2]), 64'h1000);
    bus.slew_step_i = 16'h0040;
    bus.fcw_i[2] = 32'h0000_1100;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    check("slew_ready_a",  64'(bus.fcw_ready_o[2]), 64'h0);
    check("slew_locked_a", 64'(bus.locked_o[2]),    64'h0);
    check("slew_cur_a",    64'(dut.cur_fcw_q[2]),   64'h1000);
    for (int i = 1; i < 4; i++) begin
      step();
      check("slew_ready",  64'(bus.fcw_ready_o[2]), 64'h0);
      check("slew_locked", 64'(bus.locked_o[2]),    64'h0);
      check("slew_cur",    64'(dut.cur_fcw_q[2]),   64'(32'h1000 + 32'h40 * i));
    end
    step();
    check("slew_done_ready",  64'(bus.fcw_ready_o[2]), 64'h1);
    check("slew_done_locked", 64'(bus.locked_o[2]),    64'h1);
    check("slew_done_cur",    64'(dut.cur_fcw_q[2]),   64'h1100);

    // ---------------- non-multiple ramp and step-down ----------------
    bus.slew_step_i = 16'h0000;
    bus.fcw_i[2] = 32'h0000_0100;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    step();
    check("nm_cur100", 64'(dut.cur_fcw_q[2]), 64'h100);
    bus.slew_step_i = 16'h0030;
    bus.fcw_i[2] = 32'h0000_00D0;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    check("nm_ramp_locked", 64'(bus.locked_o[2]), 64'h0);
    step();
    check("nm_curD0",    64'(dut.cur_fcw_q[2]), 64'hD0);
    check("nm_lockedD0", 64'(bus.locked_o[2]),  64'h1);
    bus.fcw_i[2] = 32'h0000_00A5;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    step();
    check("nm_curA5",    64'(dut.cur_fcw_q[2]), 64'hA5);
    check("nm_lockedA5", 64'(bus.locked_o[2]),  64'h1);
    // same value accepted in RUN keeps lock
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    check("same_locked", 64'(bus.locked_o[2]),    64'h1);
    check("same_ready",  64'(bus.fcw_ready_o[2]), 64'h1);
    // slew change mid-ramp: 0xA5 -> 0xE5 with step 0x10 then 0x20
    bus.slew_step_i = 16'h0010;
    bus.fcw_i[2] = 32'h0000_00E5;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    step();
    check("mid_curB5", 64'(dut.cur_fcw_q[2]), 64'hB5);
    bus.slew_step_i = 16'h0020;
    step();
    check("mid_curD5", 64'(dut.cur_fcw_q[2]), 64'hD5);
    step();
    check("mid_curE5",  64'(dut.cur_fcw_q[2]), 64'hE5);
    check("mid_locked", 64'(bus.locked_o[2]),  64'h1);

    // ---------------- enable and independence on ch1 ----------------
    bus.slew_step_i = 16'h0000;
    bus.fcw_i[1] = 32'h1000_0000;
    bus.fcw_valid_i[1] = 1'b1;
    step();
    bus.fcw_valid_i[1] = 1'b0;
    bus.en_i[1] = 1'b1;
    step();
    step();
    step();
    step();
    step();
    check("en_acc1", 64'(dut.acc_q[1]), 64'h3000_0000);
    bus.en_i[1] = 1'b0;
    step();
    check("dis_acc1",    64'(dut.acc_q[1]),     64'h0);
    check("dis_clk1",    64'(bus.clk_o[1]),     64'h0);
    check("dis_tick1",   64'(bus.tick_o[1]),    64'h0);
    check("dis_locked1", 64'(bus.locked_o[1]),  64'h0);
    check("dis_cur1",    64'(dut.cur_fcw_q[1]), 64'h1000_0000);
    last = -1;
    cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) bus.en_i[1] = 1'b1;
      step();
      if (bus.tick_o[0] === 1'b1) begin
        if (last >= 0) check("ch0_spacing", 64'(i - last), 64'd4);
        last = i;
        cnt++;
      end
    end
    check("ch0_tick_count", 64'(cnt), 64'd3);
    check("reen_locked1", 64'(bus.locked_o[1]), 64'h1);
    check("reen_acc1",    64'(dut.acc_q[1]),    64'h7000_0000);

    // ---------------- FCW = all ones, then FCW = 0 on ch3 ----------------
    bus.fcw_i[3] = 32'hFFFF_FFFF;
    bus.fcw_valid_i[3] = 1'b1;
    step();
    bus.fcw_valid_i[3] = 1'b0;
    bus.en_i[3] = 1'b1;
    step();
    step();
    check("max_acc_start", 64'(dut.acc_q[3]), 64'h0);
    step();
    check("max_tick_a", 64'(bus.tick_o[3]), 64'h0);
    check("max_acc_a",  64'(dut.acc_q[3]),  64'hFFFF_FFFF);
    step();
    check("max_tick_b", 64'(bus.tick_o[3]), 64'h1);
    check("max_acc_b",  64'(dut.acc_q[3]),  64'hFFFF_FFFE);
    step();
    check("max_tick_c", 64'(bus.tick_o[3]), 64'h1);
    bus.fcw_i[3] = 32'h0000_0000;
    bus.fcw_valid_i[3] = 1'b1;
    step();
    bus.fcw_valid_i[3] = 1'b0;
    step();
    step();
    step();
    step();
    check("zero_acc3",    64'(dut.acc_q[3]),   64'hFFFF_FFFB);
    check("zero_tick3",   64'(bus.tick_o[3]),  64'h0);
    check("zero_clk3",    64'(bus.clk_o[3]),   64'h1);
    check("zero_locked3", 64'(bus.locked_o[3]), 64'h1);

    // ---------------- asynchronous reset mid-ramp ----------------
    bus.slew_step_i = 16'h0001;
    bus.fcw_i[2] = 32'h0000_1000;
    bus.fcw_valid_i[2] = 1'b1;
    step();
    bus.fcw_valid_i[2] = 1'b0;
    step();
    check("pre_rst_ready2", 64'(bus.fcw_ready_o[2]), 64'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  64'(bus.fcw_ready_o), 64'hF);
    check("arst_locked", 64'(bus.locked_o),    64'h0);
    check("arst_tick",   64'(bus.tick_o),      64'h0);
    check("arst_clk",    64'(bus.clk_o),       64'h0);
    check("arst_cur2",   64'(dut.cur_fcw_q[2]), 64'h0);
    check("arst_tgt2",   64'(dut.tgt_fcw_q[2]), 64'h0);
    bus.en_i = 4'b0000;
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_ready",  64'(bus.fcw_ready_o), 64'hF);
    check("post_rst_locked", 64'(bus.locked_o),    64'h0);

`ifdef NCO_SYNC_EN
    // ---------------- sync pulse ----------------
    bus.slew_step_i = 16'h0000;
    bus.fcw_i[0] = 32'h2000_0000;
    bus.fcw_i[1] = 32'h3000_0000;
    bus.fcw_valid_i = 4'b0011;
    step();
    bus.fcw_valid_i = 4'b0000;
    bus.en_i = 4'b0011;
    step();
    step();
    step();
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_acc0",   64'(dut.acc_q[0]),      64'h0);
    check("sync_acc1",   64'(dut.acc_q[1]),      64'h0);
    check("sync_tick",   64'(bus.tick_o[1:0]),   64'h0);
    check("sync_locked", 64'(bus.locked_o[1:0]), 64'h3);
    check("sync_cur1",   64'(dut.cur_fcw_q[1]),  64'h3000_0000);
    first0 = -1;
    first1 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) check("sync_clk", 64'(bus.clk_o[1:0]), 64'h0);
      if ((bus.tick_o[0] === 1'b1) && (first0 < 0)) first0 = k;
      if ((bus.tick_o[1] === 1'b1) && (first1 < 0)) first1 = k;
    end
    check("sync_first0", 64'(first0), 64'd8);
    check("sync_first1", 64'(first1), 64'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
